mem_burst_master: RTL and testbench

Memory-access initiator for the layer controller's word-addressed memory port. It accepts a burst command (start word address, length, direction) and runs one four-phase REQ/ACK transaction per word against a memory responder. Write data is pulled from a valid/ready stream and read data is pushed to one. An ACK timeout aborts a burst when the responder hangs. It sits between command sources (message decoder, DMA sequencer) and the memory controller.

---
 rtl/mem_burst_master.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_burst_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// mem_burst_master
// Burst initiator for the layer controller's word-addressed memory port.
// A command (start word address, length, direction) is turned into one
// four-phase REQ/ACK handshake per word. Write words are pulled from a
// valid/ready stream and read words are pushed into one. A per-phase ACK
// timeout aborts the burst if the responder hangs.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   CMD_*                 burst command (valid/ready), direction, address, length
//   WR_DATA/VALID/READY   write-data stream into the master
//   RD_DATA/VALID/READY   read-data stream out of the master
//   MEM_*                 four-phase REQ/ACK port to the memory responder
//   BUSY, DONE, ERROR     status: not idle, end-of-burst pulse, sticky timeout
module mem_burst_master #(
    parameter int LC_MEM_DATA_WIDTH = 32,
    parameter int LC_MEM_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH         = 8,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CMD_VALID,
    output logic                         CMD_READY,
    input  logic                         CMD_WRITE,
    input  logic [LC_MEM_ADDR_WIDTH-3:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]         CMD_LEN,
    input  logic [LC_MEM_DATA_WIDTH-1:0] WR_DATA,
    input  logic                         WR_VALID,
    output logic                         WR_READY,
    output logic [LC_MEM_DATA_WIDTH-1:0] RD_DATA,
    output logic                         RD_VALID,
    input  logic                         RD_READY,
    output logic [LC_MEM_ADDR_WIDTH-3:0] MEM_ADDR,
    output logic [LC_MEM_DATA_WIDTH-1:0] MEM_DATA_OUT,
    output logic                         MEM_REQ,
    output logic                         MEM_WRITE,
    input  logic [LC_MEM_DATA_WIDTH-1:0] MEM_DATA_IN,
    input  logic                         MEM_ACK_IN,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         ERROR
);

    localparam int AW = LC_MEM_ADDR_WIDTH - 2;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    // Abort on the last counted cycle so REQ/RELEASE last exactly TIMEOUT_CYCLES.
    localparam logic [TW-1:0]        TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0]        TMO_ONE  = TW'(1);
    localparam logic [AW-1:0]        ADDR_ONE = AW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_PUSH    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LC_MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LC_MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   write_q, write_d;
    logic [LEN_WIDTH-1:0]   words_left_q, words_left_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   error_q, error_d;
    logic                   mem_req_q, mem_req_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   tmo_hit_s;

    // Next-state, datapath and registered-output decode for the burst FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        write_d      = write_q;
        words_left_d = words_left_q;
        error_d      = error_q;
        // A read word is released by the consumer regardless of FSM state.
        rd_valid_d   = RD_READY ? 1'b0 : rd_valid_q;
        tmo_hit_s    = TMO_EN && (tmo_cnt_q == TMO_LAST);

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    addr_d       = CMD_ADDR;
                    write_d      = CMD_WRITE;
                    words_left_d = CMD_LEN;
                    error_d      = 1'b0;
                    if (CMD_LEN == '0) begin
                        state_d = S_FINISH;
                    end else if (CMD_WRITE) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (WR_VALID) begin
                    wdata_d = WR_DATA;
                    state_d = S_REQ;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_REQ: begin
                if (MEM_ACK_IN) begin
                    if (!write_q) begin
                        rdata_d    = MEM_DATA_IN;
                        rd_valid_d = 1'b1;
                    end else begin
                        rdata_d    = rdata_q;
                    end
                    state_d = S_RELEASE;
                end else if (tmo_hit_s) begin
                    error_d      = 1'b1;
                    words_left_d = '0;
                    state_d      = S_FINISH;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RELEASE: begin
                if (!MEM_ACK_IN) begin
                    words_left_d = words_left_q - LEN_ONE;
                    addr_d       = addr_q + ADDR_ONE;
                    if (!write_q) begin
                        state_d = S_PUSH;
                    end else if (words_left_q == LEN_ONE) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (tmo_hit_s) begin
                    error_d      = 1'b1;
                    words_left_d = '0;
                    state_d      = S_FINISH;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_PUSH: begin
                // Leave on the edge that consumes the word, so the next REQ
                // never overlaps a pending read word.
                if (!rd_valid_q || RD_READY) begin
                    if (words_left_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Phase timer restarts on every state change and runs within a phase.
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end

        // Outputs are decoded from the next state so they come straight from flops.
        mem_req_d   = (state_d == S_REQ);
        done_d      = (state_d == S_FINISH);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_FETCH);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_valid_q   <= 1'b0;
            write_q      <= 1'b0;
            words_left_q <= '0;
            tmo_cnt_q    <= '0;
            error_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            wr_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rd_valid_q   <= rd_valid_d;
            write_q      <= write_d;
            words_left_q <= words_left_d;
            tmo_cnt_q    <= tmo_cnt_d;
            error_q      <= error_d;
            mem_req_q    <= mem_req_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    assign CMD_READY    = cmd_ready_q;
    assign WR_READY     = wr_ready_q;
    assign RD_DATA      = rdata_q;
    assign RD_VALID     = rd_valid_q;
    assign MEM_ADDR     = addr_q;
    assign MEM_DATA_OUT = wdata_q;
    assign MEM_REQ      = mem_req_q;
    assign MEM_WRITE    = write_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERROR        = error_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Testbench for mem_burst_master: directed table of bursts, hand-written
// corner sequences (zero length, timeout, reset mid-burst) and randomized
// bursts checked against an array model of memory.
module tb_mem_burst_master;

    localparam int DW  = 32;
    localparam int ADW = 10;
    localparam int AW  = ADW - 2;
    localparam int LW  = 8;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [LW-1:0] CMD_LEN = '0;
    logic [DW-1:0] WR_DATA = '0;
    logic          WR_VALID = 1'b0;
    logic          WR_READY;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_READY = 1'b0;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA_OUT;
    logic          MEM_REQ;
    logic          MEM_WRITE;
    logic [DW-1:0] MEM_DATA_IN;
    logic          MEM_ACK_IN;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;

    always #5 CLK = ~CLK;

    mem_burst_master #(
        .LC_MEM_DATA_WIDTH(DW), .LC_MEM_ADDR_WIDTH(ADW),
        .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA_OUT(MEM_DATA_OUT), .MEM_REQ(MEM_REQ),
        .MEM_WRITE(MEM_WRITE), .MEM_DATA_IN(MEM_DATA_IN), .MEM_ACK_IN(MEM_ACK_IN),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hC000_0000 | 32'(i * 7);
    endfunction

    // ---------------- responder model ----------------
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_mem [0:255];
    logic init_mem = 1'b1;
    logic hang = 1'b0;
    int   lat = 1;
    int   rcnt;

    // Four-phase responder: ACK after 'lat' extra cycles, drop ACK after REQ drops.
    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end
        if (RESET) begin
            MEM_ACK_IN  <= 1'b0;
            MEM_DATA_IN <= '0;
            rcnt        <= 0;
        end else if (MEM_REQ && !MEM_ACK_IN) begin
            if (!hang && rcnt >= lat) begin
                MEM_ACK_IN <= 1'b1;
                rcnt       <= 0;
                if (MEM_WRITE) mem[MEM_ADDR] <= MEM_DATA_OUT;
                else           MEM_DATA_IN   <= mem[MEM_ADDR];
            end else begin
                rcnt <= rcnt + 1;
            end
        end else if (!MEM_REQ && MEM_ACK_IN) begin
            MEM_ACK_IN <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int req_rises = 0, req_high = 0, done_cnt = 0, viol = 0;
    logic prev_req = 1'b0;
    logic [AW-1:0] addr_log[$];

    // Counts handshakes and flags REQ overlapping ACK or a pending read word.
    always @(negedge CLK) begin
        if (MEM_REQ === 1'b1 && prev_req == 1'b0) begin
            req_rises <= req_rises + 1;
            addr_log.push_back(MEM_ADDR);
            if (MEM_ACK_IN === 1'b1) viol <= viol + 1;
        end
        if (MEM_REQ === 1'b1 && RD_VALID === 1'b1) viol <= viol + 1;
        if (MEM_REQ === 1'b1) req_high <= req_high + 1;
        if (DONE === 1'b1) done_cnt <= done_cnt + 1;
        prev_req <= (MEM_REQ === 1'b1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
        int            len;
        logic [DW-1:0] wbase;
        int            mode;      // 0 always ready, 1 toggle, 2 random
        int            exp_reqs;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];

    // One complete burst with stream drivers; checks against the memory model.
    task automatic run_burst(input vec_t v);
        int r0, d0, s0, wi;
        logic seen_done;
        logic [DW-1:0] got[$];
        logic [DW-1:0] exp_rd[$];
        logic [AW-1:0] ai;
        r0 = req_rises; d0 = done_cnt; s0 = addr_log.size();
        for (int i = 0; i < v.len; i++) begin
            ai = v.addr + AW'(i);
            if (v.w) exp_mem[ai] = v.wbase + 32'(i);
            else     exp_rd.push_back(exp_mem[ai]);
        end
        @(negedge CLK);
        check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1; CMD_WRITE = v.w; CMD_ADDR = v.addr; CMD_LEN = LW'(v.len);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        check("error_clr_on_accept", 32'(ERROR), 32'd0);
        seen_done = 1'b0; wi = 0;
        for (int c = 0; c < 500 && !seen_done; c++) begin
            @(negedge CLK);
            if (DONE) begin
                seen_done = 1'b1;
            end else begin
                WR_DATA  = v.wbase + 32'(wi);
                WR_VALID = v.w && (wi < v.len) && (v.mode != 2 || ($urandom % 2) == 0);
                RD_READY = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? ((c % 2) == 0) : 1'(($urandom % 2));
                if (WR_VALID && WR_READY) wi++;
                if (RD_VALID && RD_READY) got.push_back(RD_DATA);
            end
        end
        WR_VALID = 1'b0; RD_READY = 1'b0;
        @(negedge CLK);
        check("done_seen", 32'(seen_done), 32'd1);
        check("req_rises", 32'(req_rises - r0), 32'(v.exp_reqs));
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("error_end", 32'(ERROR), 32'(v.exp_err));
        check("busy_end", 32'(BUSY), 32'd0);
        for (int i = 0; i < v.len; i++) begin
            ai = v.addr + AW'(i);
            if (s0 + i < addr_log.size()) check("addr_seq", 32'(addr_log[s0 + i]), 32'(ai));
            else                          check("addr_seq_missing", 32'd0, 32'd1);
            if (v.w) check("mem_word", mem[ai], exp_mem[ai]);
        end
        if (!v.w) begin
            check("rd_count", 32'(got.size()), 32'(v.len));
            for (int i = 0; i < v.len && i < got.size(); i++) check("rd_data", got[i], exp_rd[i]);
        end
    endtask

    initial begin
        int r0, d0, h0, rises;
        logic p, seen_done;
        vec_t rv;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        vecs[0] = '{1'b1, 8'h10, 4, 32'hA0, 0, 4, 1'b0};
        vecs[1] = '{1'b0, 8'h10, 4, 32'h0,  1, 4, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 2, 32'hB0, 0, 2, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 2, 32'h0,  2, 2, 1'b0};
        vecs[4] = '{1'b1, 8'h40, 1, 32'hC0, 2, 1, 1'b0};
        vecs[5] = '{1'b0, 8'h40, 1, 32'h0,  1, 1, 1'b0};

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0; init_mem = 1'b0;
        @(negedge CLK);
        check("rst_mem_req",   32'(MEM_REQ),   32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_rd_valid",  32'(RD_VALID),  32'd0);
        check("rst_done",      32'(DONE),      32'd0);
        check("rst_error",     32'(ERROR),     32'd0);
        check("rst_busy",      32'(BUSY),      32'd0);
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_wr_ready",  32'(WR_READY),  32'd0);
        check("rst_mem_addr",  32'(MEM_ADDR),  32'd0);
        check("rst_data_out",  MEM_DATA_OUT,   32'd0);
        check("rst_rd_data",   RD_DATA,        32'd0);

        // Directed table.
        for (int k = 0; k < 6; k++) run_burst(vecs[k]);

        // Zero-length command: DONE right after acceptance, no memory access.
        r0 = req_rises;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h22; CMD_LEN = '0;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        check("len0_done_rise", 32'(DONE), 32'd1);
        check("len0_busy",      32'(BUSY), 32'd1);
        check("len0_no_req",    32'(MEM_REQ), 32'd0);
        @(posedge CLK); #1;
        check("len0_done_fall", 32'(DONE), 32'd0);
        check("len0_busy_fall", 32'(BUSY), 32'd0);
        check("len0_cmd_ready", 32'(CMD_READY), 32'd1);
        repeat (2) @(negedge CLK);
        check("len0_req_count", 32'(req_rises - r0), 32'd0);

        // Timeout: responder never acknowledges.
        hang = 1'b1;
        h0 = req_high; d0 = done_cnt;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h60; CMD_LEN = 8'd2;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge CLK);
            if (DONE) begin
                seen_done = 1'b1;
                check("tmo_req_low_at_done", 32'(MEM_REQ), 32'd0);
                check("tmo_error_at_done",   32'(ERROR),   32'd1);
            end else begin
                WR_VALID = 1'b1; WR_DATA = 32'hDEAD_0000;
            end
        end
        WR_VALID = 1'b0;
        check("tmo_done_seen", 32'(seen_done), 32'd1);
        repeat (3) @(negedge CLK);
        check("tmo_req_cycles", 32'(req_high - h0), 32'(TMO));
        check("tmo_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("tmo_error_sticky", 32'(ERROR), 32'd1);
        check("tmo_mem_untouched", mem[8'h60], exp_mem[8'h60]);
        hang = 1'b0;
        rv = '{1'b1, 8'h61, 3, 32'h7700, 0, 3, 1'b0};
        run_burst(rv);

        // Reset in the middle of a 4-word write, while the third REQ is up.
        lat = 1; rises = 0; p = 1'b0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h80; CMD_LEN = 8'd4;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        d0 = 0;
        for (int c = 0; c < 100 && rises < 3; c++) begin
            @(negedge CLK);
            if (MEM_REQ && !p) rises++;
            p = MEM_REQ;
            if (WR_READY) begin
                WR_DATA = 32'h5500 + 32'(d0); WR_VALID = 1'b1; d0++;
            end else begin
                WR_VALID = 1'b0;
            end
        end
        check("rstmid_reached", 32'(rises), 32'd3);
        WR_VALID = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("rstmid_req",       32'(MEM_REQ),   32'd0);
        check("rstmid_busy",      32'(BUSY),      32'd0);
        check("rstmid_done",      32'(DONE),      32'd0);
        check("rstmid_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rstmid_wr_ready",  32'(WR_READY),  32'd0);
        check("rstmid_addr",      32'(MEM_ADDR),  32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        exp_mem[8'h80] = 32'h5500;
        exp_mem[8'h81] = 32'h5501;
        for (int i = 0; i < 4; i++) check("rstmid_mem", mem[8'h80 + i], exp_mem[8'h80 + i]);

        // Randomized bursts against the memory model.
        for (int k = 0; k < 20; k++) begin
            lat = int'($urandom % 4);
            rv.w        = 1'($urandom % 2);
            rv.addr     = AW'($urandom % 256);
            rv.len      = 1 + int'($urandom % 6);
            rv.wbase    = $urandom;
            rv.mode     = 2;
            rv.exp_reqs = rv.len;
            rv.exp_err  = 1'b0;
            run_burst(rv);
        end

        check("protocol_violations", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
